// File: rtl/priority_encoder_8to3_queued.sv
// ----------------------------------------------------------------------------
// priority_encoder_8to3_queued
//
// Registered 8-to-3 priority encoder with request queueing. Request lines are
// OR'd into a pending set every clock edge. The highest-priority pending bit
// is handed out as a 3-bit code over a valid/ready handshake. Each code that
// is loaded into code_out clears its pending bit.
//
// Parameters
//   PRIO_MSB    1: bit 7 has the highest priority; 0: bit 0 has the highest.
//
// Ports
//   clk         in   1  clock; all state changes on the rising edge
//   rst         in   1  asynchronous, active-high reset
//   req         in   8  request lines, OR'd into the pending set each edge
//   code_out    out  3  binary index of the presented request
//   code_valid  out  1  code_out holds a valid index
//   code_ready  in   1  consumer accepts code_out when valid && ready
//   pending     out  8  current pending set (registered)
//   ovf         out  1  sticky: a request arrived on a bit already pending
//   ovf_clr     in   1  clears ovf; a same-cycle set condition wins
// ----------------------------------------------------------------------------
module priority_encoder_8to3_queued #(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] pending,
  output logic       ovf,
  input  logic       ovf_clr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pending;
  logic [2:0] r_code;
  logic       r_valid;
  logic       r_ovf;

  logic [2:0] w_sel;
  logic       w_any;
  logic       w_load;
  logic [7:0] w_clr_mask;
  logic [7:0] w_pending_next;
  logic       w_ovf_set;

  // Index of the highest-priority set bit. The loop runs from the lowest to
  // the highest priority so the last hit is the winner.
  function automatic logic [2:0] f_select(input logic [7:0] vec,
                                          input logic       msb_first);
    logic [2:0] idx;
    idx = 3'd0;
    if (msb_first) begin
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) begin
          idx = 3'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (vec[i]) begin
          idx = 3'(i);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

  // Selection, load decision and next pending set. Selection uses only the
  // registered pending set, so same-cycle requests are never bypassed.
  always_comb begin
    w_sel  = f_select(r_pending, PRIO_MSB);
    w_any  = |r_pending;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = w_any;
      ST_HOLD: w_load = w_any & code_ready;
      default: w_load = 1'b0;
    endcase
    if (w_load) begin
      w_clr_mask = 8'd1 << w_sel;
    end else begin
      w_clr_mask = 8'd0;
    end
    // The OR with req comes last, so a request on the bit being loaded
    // this edge re-pends it and it is served a second time.
    w_pending_next = (r_pending & ~w_clr_mask) | req;
    w_ovf_set      = |(req & r_pending);
  end

  // Pending set, sticky overflow and the handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 8'd0;
      r_code    <= 3'd0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_code  <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // No preemption: the presented code stays until it is accepted.
          if (code_ready) begin
            if (w_load) begin
              r_code  <= w_sel;
              r_valid <= 1'b1;
            end else begin
              // code_out keeps its last value when valid drops.
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign code_out   = r_code;
  assign code_valid = r_valid;
  assign pending    = r_pending;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_priority_encoder_8to3_queued.sv
// ----------------------------------------------------------------------------
// Testbench for priority_encoder_8to3_queued. Two instances share all inputs:
// u_dut_msb (PRIO_MSB=1) and u_dut_lsb (PRIO_MSB=0). Inputs change and
// outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_priority_encoder_8to3_queued;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       code_ready;
  logic       ovf_clr;

  logic [2:0] m_code;
  logic       m_valid;
  logic [7:0] m_pending;
  logic       m_ovf;

  logic [2:0] l_code;
  logic       l_valid;
  logic [7:0] l_pending;
  logic       l_ovf;

  int checks;
  int errors;

  priority_encoder_8to3_queued #(.PRIO_MSB(1'b1)) u_dut_msb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .code_out   (m_code),
    .code_valid (m_valid),
    .code_ready (code_ready),
    .pending    (m_pending),
    .ovf        (m_ovf),
    .ovf_clr    (ovf_clr)
  );

  priority_encoder_8to3_queued #(.PRIO_MSB(1'b0)) u_dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .code_out   (l_code),
    .code_valid (l_valid),
    .code_ready (code_ready),
    .pending    (l_pending),
    .ovf        (l_ovf),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req        = 8'h00;
    code_ready = 1'b0;
    ovf_clr    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_code, m_valid, m_pending, m_ovf} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got code=%0d valid=%b pend=%h ovf=%b, expected all 0",
               m_code, m_valid, m_pending, m_ovf);
    end
    req = 8'h20;
    @(negedge clk);
    req = 8'h00;
    checks++;
    if (m_pending !== 8'h20 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: got pend=%h valid=%b, expected pend=20 valid=0",
               m_pending, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_code !== 3'd5 || m_pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_code5: got valid=%b code=%0d pend=%h, expected valid=1 code=5 pend=00",
               m_valid, m_code, m_pending);
    end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_code !== 3'd5) begin
      errors++;
      $display("FAIL reset_drop_hold: got valid=%b code=%0d, expected valid=0 code=5 (held)",
               m_valid, m_code);
    end
  endtask

  task automatic test_priority_stall();
    do_reset();
    req = 8'h81;
    @(negedge clk);
    req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_code !== 3'd7) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b code=%0d, expected valid=1 code=7",
                 i, m_valid, m_code);
      end
    end
    code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_code !== 3'd0 || m_pending !== 8'h00) begin
      errors++;
      $display("FAIL stall_next: got valid=%b code=%0d pend=%h, expected valid=1 code=0 pend=00",
               m_valid, m_code, m_pending);
    end
    @(negedge clk);
    code_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got valid=%b, expected 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_m;
    logic [2:0] exp_l;
    do_reset();
    code_ready = 1'b1;
    req        = 8'hFF;
    @(negedge clk);
    req = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_m = 3'(7 - i);
      exp_l = 3'(i);
      checks++;
      if (m_valid !== 1'b1 || m_code !== exp_m) begin
        errors++;
        $display("FAIL b2b_msb[%0d]: got valid=%b code=%0d, expected valid=1 code=%0d",
                 i, m_valid, m_code, exp_m);
      end
      checks++;
      if (l_valid !== 1'b1 || l_code !== exp_l) begin
        errors++;
        $display("FAIL b2b_lsb[%0d]: got valid=%b code=%0d, expected valid=1 code=%0d",
                 i, l_valid, l_code, exp_l);
      end
    end
    @(negedge clk);
    code_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got msb_valid=%b lsb_valid=%b, expected 0 0", m_valid, l_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    req = 8'h04;
    @(negedge clk);
    checks++;
    if (m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first_req: got ovf=%b, expected 0", m_ovf);
    end
    req = 8'h04;
    @(negedge clk);
    req = 8'h00;
    checks++;
    if (m_ovf !== 1'b1 || m_pending !== 8'h04) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b pend=%h, expected ovf=1 pend=04", m_ovf, m_pending);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b, expected 1", m_ovf);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b, expected 0", m_ovf);
    end
    // bit 2 is still pending (consumer stalled), so this is a duplicate
    ovf_clr = 1'b1;
    req     = 8'h04;
    @(negedge clk);
    ovf_clr = 1'b0;
    req     = 8'h00;
    checks++;
    if (m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got ovf=%b, expected 1", m_ovf);
    end
  endtask

  task automatic test_set_beats_clear();
    int served;
    served = 0;
    do_reset();
    code_ready = 1'b1;
    req        = 8'h10;
    @(negedge clk);
    req = 8'h10;     // arrives on the edge where bit 4 is loaded
    @(negedge clk);
    req = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (m_valid === 1'b1 && m_code === 3'd4) begin
        served++;
      end
      @(negedge clk);
    end
    code_ready = 1'b0;
    checks++;
    if (served !== 2) begin
      errors++;
      $display("FAIL set_beats_clear: got %0d presentations of code 4, expected 2", served);
    end
    checks++;
    if (m_valid !== 1'b0 || m_pending !== 8'h00) begin
      errors++;
      $display("FAIL set_beats_clear_end: got valid=%b pend=%h, expected valid=0 pend=00",
               m_valid, m_pending);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h0C;
    @(negedge clk);
    req = 8'h0C;     // re-pend bit 3 as it is loaded, leaving 0C pending
    @(negedge clk);
    req = 8'h00;
    checks++;
    if (m_valid !== 1'b1 || m_code !== 3'd3 || m_pending !== 8'h0C) begin
      errors++;
      $display("FAIL async_pre: got valid=%b code=%0d pend=%h, expected valid=1 code=3 pend=0C",
               m_valid, m_code, m_pending);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_code, m_valid, m_pending, m_ovf} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got code=%0d valid=%b pend=%h ovf=%b, expected all 0",
               m_code, m_valid, m_pending, m_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req        = 8'h00;
    code_ready = 1'b0;
    ovf_clr    = 1'b0;
    test_reset();
    test_priority_stall();
    test_back_to_back();
    test_overflow();
    test_set_beats_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
